// File: rtl/ds18b20_pkg.sv
// Shared op codes, DS18B20 command bytes and scheduler state encoding.
package ds18b20_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } op_code_t;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RST1, ST_SKIP1, ST_CONV, ST_WAIT_CONV,
    ST_RST2, ST_SKIP2, ST_RDCMD, ST_RD_LO, ST_RD_HI, ST_DONE
  } state_t;

  typedef struct packed {
    logic     issue;
    op_code_t code;
    logic [7:0] wdata;
  } op_t;

  // Engine op launched on entry to a state; issue=0 for non-op states.
  function automatic op_t op_for(state_t s);
    op_t o;
    o = '{issue: 1'b1, code: OP_WRITE, wdata: 8'h00};
    case (s)
      ST_RST1, ST_RST2:   o.code  = OP_RESET;
      ST_SKIP1, ST_SKIP2: o.wdata = CMD_SKIP_ROM;
      ST_CONV:            o.wdata = CMD_CONVERT;
      ST_RDCMD:           o.wdata = CMD_READ_SP;
      ST_RD_LO, ST_RD_HI: o.code  = OP_READ;
      default:            o.issue = 1'b0;
    endcase
    return o;
  endfunction

  function automatic state_t next_state(state_t s);
    case (s)
      ST_IDLE:      return ST_RST1;
      ST_RST1:      return ST_SKIP1;
      ST_SKIP1:     return ST_CONV;
      ST_CONV:      return ST_WAIT_CONV;
      ST_WAIT_CONV: return ST_RST2;
      ST_RST2:      return ST_SKIP2;
      ST_SKIP2:     return ST_RDCMD;
      ST_RDCMD:     return ST_RD_LO;
      ST_RD_LO:     return ST_RD_HI;
      ST_RD_HI:     return ST_DONE;
      default:      return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ds18b20_sched_if.sv
// Request/ack/done handshake between the scheduler and the 1-Wire byte engine.
interface ds18b20_sched_if;
  import ds18b20_pkg::*;

  logic       op_req;
  op_code_t   op_code;
  logic [7:0] op_wdata;
  logic       op_ack;
  logic       op_done;
  logic [7:0] op_rdata;
  logic       op_presence;

  modport master (
    output op_req, op_code, op_wdata,
    input  op_ack, op_done, op_rdata, op_presence
  );

  modport slave (
    input  op_req, op_code, op_wdata,
    output op_ack, op_done, op_rdata, op_presence
  );
endinterface

// File: rtl/ow_tick_gen.sv
// Free-running 1 us and 1 ms single-cycle tick pulses derived from CLK_HZ.
module ow_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick,
  output logic ms_tick
);
  localparam int US_DIV = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int MS_DIV = (CLK_HZ / 1_000 > 0) ? CLK_HZ / 1_000 : 1;
  localparam int UW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int MW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [UW-1:0] US_LAST = UW'(US_DIV - 1);
  localparam logic [MW-1:0] MS_LAST = MW'(MS_DIV - 1);

  logic [UW-1:0] us_cnt;
  logic [MW-1:0] ms_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt  <= '0;
      ms_cnt  <= '0;
      us_tick <= 1'b0;
      ms_tick <= 1'b0;
    end else begin
      us_tick <= (us_cnt == US_LAST);
      ms_tick <= (ms_cnt == MS_LAST);
      us_cnt  <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
      ms_cnt  <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ds18b20_sched.sv
// DS18B20 measurement scheduler: sequences byte-engine ops for one conversion
// and scratchpad temperature readout, triggered manually or periodically.
module ds18b20_sched
  import ds18b20_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int CONV_MS    = 750,
  parameter int PERIOD_MS  = 1000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_req,
  input  logic             auto_en,
  ds18b20_sched_if.master  op,
  output logic [15:0]      temp_raw,
  output logic             temp_valid,
  output logic             busy,
  output logic             err_no_dev
);
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int CW = $clog2(CONV_MS + 1);
  localparam int PW = $clog2(PERIOD_MS + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_US - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_MS - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_MS - 1);

  logic          us_tick, ms_tick;
  state_t        state, adv;
  op_t           nxt_op;
  logic          acked, pending, step, abort, per_hit, is_reset_st;
  logic [TW-1:0] to_cnt;
  logic [CW-1:0] wc_cnt;
  logic [PW-1:0] per_cnt;
  logic [7:0]    lo_q, hi_q;

  ow_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .us_tick (us_tick),
    .ms_tick (ms_tick)
  );

  assign busy    = (state != ST_IDLE);
  assign adv     = next_state(state);
  assign nxt_op  = op_for(adv);
  assign per_hit = auto_en && ms_tick && (per_cnt == PER_LAST);
  assign is_reset_st = (state == ST_RST1) || (state == ST_RST2);

  always_ff @(posedge clk) begin
    if (rst || !auto_en) per_cnt <= '0;
    else if (ms_tick)    per_cnt <= per_hit ? '0 : per_cnt + 1'b1;
  end

  // acked is only ever set in op states, so it gates done/timeout handling.
  always_comb begin
    step  = 1'b0;
    abort = 1'b0;
    case (state)
      ST_IDLE:      step = pending;
      ST_WAIT_CONV: step = ms_tick && (wc_cnt == CONV_LAST);
      ST_DONE:      step = 1'b1;
      default: begin
        if (acked && op.op_done) begin
          if (is_reset_st && !op.op_presence) abort = 1'b1;
          else                                step  = 1'b1;
        end else if (acked && us_tick && to_cnt == TO_LAST) begin
          abort = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op.op_req   <= 1'b0;
      op.op_code  <= OP_RESET;
      op.op_wdata <= 8'h00;
      temp_raw    <= 16'h0000;
      temp_valid  <= 1'b0;
      err_no_dev  <= 1'b0;
      pending     <= 1'b0;
      acked       <= 1'b0;
      to_cnt      <= '0;
      wc_cnt      <= '0;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
    end else begin
      temp_valid <= 1'b0;
      if (op.op_req && op.op_ack) begin
        op.op_req <= 1'b0;
        acked     <= 1'b1;
        to_cnt    <= '0;
      end else if (acked && us_tick) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state == ST_WAIT_CONV && ms_tick) wc_cnt <= wc_cnt + 1'b1;
      if (state == ST_RD_LO && step) lo_q <= op.op_rdata;
      if (state == ST_RD_HI && step) hi_q <= op.op_rdata;
      if (state == ST_DONE) begin
        temp_raw   <= {hi_q, lo_q};
        temp_valid <= 1'b1;
        err_no_dev <= 1'b0;
      end
      if (abort) begin
        err_no_dev <= 1'b1;
        acked      <= 1'b0;
        state      <= ST_IDLE;
      end else if (step) begin
        state  <= adv;
        acked  <= 1'b0;
        wc_cnt <= '0;
        if (state == ST_IDLE) pending <= 1'b0;
        if (nxt_op.issue) begin
          op.op_req   <= 1'b1;
          op.op_code  <= nxt_op.code;
          op.op_wdata <= nxt_op.wdata;
        end
      end
      // A new request in the same cycle IDLE consumes pending must not be lost.
      if (start_req || per_hit) pending <= 1'b1;
    end
  end
endmodule

// File: doc/ds18b20_sched.md
DS18B20_SCHED -- requirements
Module: ds18b20_sched

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter CONV_MS, default 750, conversion wait in ms.
REQ-003 Parameter PERIOD_MS, default 1000, auto-trigger period in ms.
REQ-004 Parameter TIMEOUT_US, default 2000, max op_ack-to-op_done time in us.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start_req  in  1  one-cycle manual measurement request.
REQ-008 auto_en  in  1  level; enables periodic measurements.
REQ-009 op_req  out  1  request to 1-Wire byte engine.
REQ-010 op_code  out  2  00 RESET, 01 WRITE_BYTE, 10 READ_BYTE.
REQ-011 op_wdata  out  8  byte to write, LSB sent first by engine.
REQ-012 op_ack  in  1  engine accepted request.
REQ-013 op_done  in  1  one-cycle completion pulse.
REQ-014 op_rdata  in  8  read byte, valid with op_done.
REQ-015 op_presence  in  1  presence detected, valid with op_done of RESET.
REQ-016 temp_raw  out  16  last raw scratchpad temperature {MSB,LSB}.
REQ-017 temp_valid  out  1  one-cycle pulse when temp_raw updates.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 err_no_dev  out  1  sticky: presence missing or op timeout.

Function
REQ-020 States: IDLE, RST1, SKIP1, CONV, WAIT_CONV, RST2, SKIP2, RDCMD, RD_LO, RD_HI, DONE.
REQ-021 Op sequence: RST1(RESET), SKIP1(WRITE CC), CONV(WRITE 44), WAIT_CONV, RST2(RESET), SKIP2(WRITE CC), RDCMD(WRITE BE), RD_LO(READ), RD_HI(READ), DONE.
REQ-022 Op handshake: op_req rises on state entry; op_code/op_wdata stable while op_req high; op_req drops the cycle after op_ack sampled high; state advances on op_done.
REQ-023 op_done without prior op_ack is ignored.
REQ-024 Timeout: us counter starts at op_ack; reaching TIMEOUT_US before op_done sets err_no_dev, returns to IDLE, no temp_valid.
REQ-025 RESET op_done with op_presence=0 sets err_no_dev and returns to IDLE.
REQ-026 WAIT_CONV lasts exactly CONV_MS ms ticks after CONV op_done; no op_req during it.
REQ-027 RD_LO op_rdata latched to lo byte; RD_HI op_rdata to hi byte.
REQ-028 DONE: temp_raw <= {hi,lo}, temp_valid=1 for one cycle, err_no_dev cleared, next cycle IDLE.
REQ-029 Period counter counts ms ticks while auto_en=1; at PERIOD_MS sets pending and reloads 0; auto_en=0 clears counter.
REQ-030 start_req sets pending in any state; pending is one-deep; simultaneous start_req and period expiry yield one pending.
REQ-031 IDLE with pending: clear pending, enter RST1 next cycle.
REQ-032 Abort (timeout/no presence) keeps pending; retry begins from RST1 once IDLE.
REQ-033 ms tick: one-cycle pulse every CLK_HZ/1000 clocks; us tick every CLK_HZ/1_000_000 clocks; both free-running.
REQ-034 temp_raw holds value across aborts; no sign or scaling processing here.

Reset
REQ-035 rst high at clk edge: state IDLE, op_req 0, op_code 00, op_wdata 00, temp_raw 0000, temp_valid 0, busy 0, err_no_dev 0, pending 0, all counters 0.
REQ-036 rst mid-operation abandons the transaction immediately; engine outstanding op_done after rst is ignored.

Structure
REQ-037 Shared package ds18b20_pkg holds op_code constants, command bytes CC/44/BE and the state encoding.
REQ-038 One sub-module ow_tick_gen produces us and ms tick pulses from CLK_HZ.

Verification
REQ-039 start_req pulse, engine model acks in 1 cycle, presence=1, reads 50h then 05h -> ops RESET,CC,44,wait 750 ms,RESET,CC,BE,READ,READ; temp_raw=0550h, one temp_valid.
REQ-040 RST1 done with op_presence=0 -> err_no_dev=1, busy=0 next cycle, no temp_valid; subsequent good cycle clears err_no_dev.
REQ-041 Engine withholds op_done after ack -> err_no_dev=1 exactly 2000 us after ack, state IDLE.
REQ-042 auto_en=1, PERIOD_MS=10, CONV_MS=2 scaled run -> temp_valid every full period, start_req during busy causes exactly one extra cycle.
REQ-043 rst asserted during WAIT_CONV -> all outputs at reset values next cycle; late op_done ignored; new start_req runs normally.
REQ-044 op_ack delayed 5 cycles -> op_req, op_code, op_wdata stable for all 5 cycles, op_req low cycle after ack.
